// File: rtl/uart_reg_master.sv
// uart_reg_master: turns one command byte into a register-bus transaction
// sequence on a UART-like peripheral: load DATA_TX, kick CONTROL, poll
// STATUS until done (or give up), clear CONTROL, read DATA_RX, and return
// the received byte as a response.
//
// Handshakes: cmd and rsp are plain valid/ready. A transfer happens on a
// rising edge where valid and ready are both high. The producer holds
// valid and data until the transfer. The block raises ready only when it
// can accept (cmd_ready only in IDLE). Once rsp_valid is raised, it holds
// and rsp_data/rsp_err stay stable until rsp_ready is seen.
//
// Register map: 0=CONTROL (wr), 1=DATA_TX (wr), 2=STATUS (rd), 3=DATA_RX (rd).
// rd_data is valid on the cycle after rd_en. In STATUS, bit1 is busy and
// bit0 is done.
module uart_reg_master #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   CTRL_VAL = 'h01,
    parameter int                 POLL_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cmd_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             wr_en,
    output logic [1:0]       wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             rd_en,
    output logic [1:0]       rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_TX     = 4'd1,
        S_WR_CTRL   = 4'd2,
        S_RD_STAT   = 4'd3,
        S_WAIT_STAT = 4'd4,
        S_WR_CLR    = 4'd5,
        S_RD_RX     = 4'd6,
        S_WAIT_RX   = 4'd7,
        S_RESP      = 4'd8
    } state_t;

    localparam logic [1:0] ADDR_CONTROL = 2'd0;
    localparam logic [1:0] ADDR_DATA_TX = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_DATA_RX = 2'd3;

    // The poll counter is always 8 bits, whatever WIDTH is.
    localparam logic [7:0] POLL_LIM = 8'(POLL_MAX);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tx_byte;
    logic [7:0]       poll_cnt;
    logic [7:0]       poll_cnt_inc;
    logic             err;
    logic [WIDTH-1:0] rsp_data_q;
    logic             stat_done;
    logic             poll_last;
    logic             accept;

    assign accept       = (state == S_IDLE) && cmd_valid;
    assign stat_done    = (rd_data[1:0] == 2'b01);
    assign poll_cnt_inc = poll_cnt + 8'd1;
    // The counter is tested after it is incremented, so POLL_MAX evaluations
    // happen before the timeout fires.
    assign poll_last    = (poll_cnt_inc == POLL_LIM);

    assign rsp_data  = rsp_data_q;
    assign rsp_err   = err;
    assign state_dbg = state;

    // State register; reset abandons any in-flight transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the transfer sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = S_WR_TX;
                end
            end
            S_WR_TX:   state_nxt = S_WR_CTRL;
            S_WR_CTRL: state_nxt = S_RD_STAT;
            S_RD_STAT: state_nxt = S_WAIT_STAT;
            S_WAIT_STAT: begin
                if (stat_done || poll_last) begin
                    state_nxt = S_WR_CLR;
                end else begin
                    state_nxt = S_RD_STAT;
                end
            end
            S_WR_CLR: begin
                if (err) begin
                    state_nxt = S_RESP;
                end else begin
                    state_nxt = S_RD_RX;
                end
            end
            S_RD_RX:   state_nxt = S_WAIT_RX;
            S_WAIT_RX: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Bus strobes and handshake flags decoded from the current state.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 2'd0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr   = 2'd0;
        case (state)
            S_IDLE: cmd_ready = 1'b1;
            S_WR_TX: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_DATA_TX;
                wr_data = tx_byte;
            end
            S_WR_CTRL: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_CONTROL;
                wr_data = CTRL_VAL;
            end
            S_RD_STAT: begin
                rd_en   = 1'b1;
                rd_addr = ADDR_STATUS;
            end
            S_WR_CLR: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_CONTROL;
                wr_data = '0;
            end
            S_RD_RX: begin
                rd_en   = 1'b1;
                rd_addr = ADDR_DATA_RX;
            end
            S_RESP: rsp_valid = 1'b1;
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Transfer datapath: captured byte, poll counter, error flag, response byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_byte    <= '0;
            poll_cnt   <= 8'd0;
            err        <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                // Response starts at 0, so an error response keeps rsp_data=0.
                tx_byte    <= cmd_data;
                poll_cnt   <= 8'd0;
                err        <= 1'b0;
                rsp_data_q <= '0;
            end
            if (state == S_WAIT_STAT) begin
                poll_cnt <= poll_cnt_inc;
                if (!stat_done && poll_last) begin
                    err <= 1'b1;
                end
            end
            if (state == S_WAIT_RX) begin
                rsp_data_q <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_reg_master.sv
// Bench for uart_reg_master: a behavioural register slave answers STATUS and
// DATA_RX reads; each command's expected bus operations, latency and response
// are derived from the slave scenario (busy poll count, rx byte) and checked.
module tb_uart_reg_master;

    localparam int         POLL_MAX = 4;
    localparam logic [7:0] CTRL_VAL = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic [3:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    // Expected bus ops: {is_read, addr, write data (0 for reads)}.
    logic [10:0] exp_q[$];

    // Slave scenario for the current command.
    int         cur_busy = 0;
    logic [7:0] cur_rx   = 8'h00;
    int         stat_cnt = 0;

    uart_reg_master #(
        .WIDTH    (8),
        .CTRL_VAL (CTRL_VAL),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .state_dbg (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bus invariants: never both strobes, cmd_ready only in IDLE (state 0).
    always @(posedge clk) begin
        assert (!(wr_en && rd_en)) else $error("wr_en and rd_en together");
        assert (!cmd_ready || state_dbg == 4'd0) else $error("cmd_ready outside idle");
    end

    // Bus monitor and register slave, sampled mid-cycle.
    always @(negedge clk) begin
        logic [10:0] obs;
        logic [7:0]  r;
        if (!rst && (wr_en || rd_en)) begin
            obs = {rd_en, rd_en ? rd_addr : wr_addr, wr_en ? wr_data : 8'h00};
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(obs), 32'h7FF);
            end else begin
                check("bus_op", 32'(obs), 32'(exp_q.pop_front()));
            end
            if (rd_en) begin
                r = 8'($urandom);
                if (rd_addr == 2'd2) begin
                    rd_data = (r & 8'hFC) | ((stat_cnt < cur_busy) ? 8'h02 : 8'h01);
                    stat_cnt++;
                end else begin
                    rd_data = cur_rx;
                end
            end
        end
    end

    // Sets up the slave and the expected op list, then completes the handshake.
    task automatic start_cmd(input logic [7:0] cmd, input int busy, input logic [7:0] rx,
                             output int polls, output bit tmo);
        int w;
        cur_busy = busy;
        cur_rx   = rx;
        stat_cnt = 0;
        tmo   = (busy >= POLL_MAX);
        polls = tmo ? POLL_MAX : busy + 1;
        exp_q.push_back({1'b0, 2'd1, cmd});
        exp_q.push_back({1'b0, 2'd0, CTRL_VAL});
        for (int i = 0; i < polls; i++) exp_q.push_back({1'b1, 2'd2, 8'h00});
        exp_q.push_back({1'b0, 2'd0, 8'h00});
        if (!tmo) exp_q.push_back({1'b1, 2'd3, 8'h00});
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        @(posedge clk);
        #1;
        // Junk offered while busy must be ignored.
        cmd_valid = 1'($urandom);
        cmd_data  = 8'($urandom);
    endtask

    task automatic do_txn(input logic [7:0] cmd, input int busy, input logic [7:0] rx, input int hold);
        int polls;
        bit tmo;
        int k;
        int lat;
        logic [7:0] held;
        start_cmd(cmd, busy, rx, polls, tmo);
        lat = tmo ? 2 * polls + 4 : 2 * polls + 6;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (k == 3) cmd_valid = 1'b0;
            if (rsp_valid) break;
            check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        check("latency", 32'(k), 32'(lat));
        check("rsp_data", 32'(rsp_data), tmo ? 32'd0 : 32'(rx));
        check("rsp_err", 32'(rsp_err), 32'(tmo));
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'(held));
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_released", 32'(rsp_valid), 32'd0);
        check("back_idle", 32'(cmd_ready), 32'd1);
        check("ops_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Watchdog against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Test sequence.
    initial begin
        int polls;
        bit tmo;
        int w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single transfer, done on the first poll.
        do_txn(8'hA5, 0, 8'h3C, 0);
        // Slow slave: three busy polls.
        do_txn(8'h5A, 3, 8'hC3, 0);
        // Timeout: done never set.
        do_txn(8'h77, 100, 8'hEE, 0);
        // Backpressure on the response.
        do_txn(8'h12, 1, 8'h9D, 5);

        // Reset during the first STATUS read.
        start_cmd(8'h44, 5, 8'h21, polls, tmo);
        cmd_valid = 1'b0;
        w = 0;
        while (!(rd_en && rd_addr == 2'd2) && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("reach_rd_stat", 32'(rd_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_txn(8'h99, 0, 8'h66, 0);

        // Randomized commands.
        for (int i = 0; i < 24; i++) begin
            do_txn(8'($urandom), int'($urandom_range(0, 6)), 8'($urandom),
                   int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_reg_master.md
UART_REG_MASTER -- requirements
Module: uart_reg_master

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the register bus and of the command/response bytes.
REQ-002 SHALL have parameter CTRL_VAL, default 8'h01, value written to the CONTROL register to start a transfer.
REQ-003 SHALL have parameter POLL_MAX, default 255, maximum STATUS evaluations before timeout (range 1..255).
REQ-004 SHALL have port: clk  input  1  rising-edge clock; the block has one clock and reset is synchronous and active-high.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: cmd_valid  input  1  a byte to transmit is offered.
REQ-007 SHALL have port: cmd_data  input  WIDTH  byte to transmit.
REQ-008 SHALL have port: cmd_ready  output  1  block accepts a command.
REQ-009 SHALL have port: rsp_valid  output  1  response is available.
REQ-010 SHALL have port: rsp_ready  input  1  consumer accepts the response.
REQ-011 SHALL have port: rsp_data  output  WIDTH  received byte, or 0 on error.
REQ-012 SHALL have port: rsp_err  output  1  transfer timed out.
REQ-013 SHALL have port: wr_en  output  1  register-bus write strobe.
REQ-014 SHALL have port: wr_addr  output  2  write address: 0=CONTROL, 1=DATA_TX.
REQ-015 SHALL have port: wr_data  output  WIDTH  write data.
REQ-016 SHALL have port: rd_en  output  1  register-bus read strobe.
REQ-017 SHALL have port: rd_addr  output  2  read address: 2=STATUS, 3=DATA_RX.
REQ-018 SHALL have port: rd_data  input  WIDTH  read data, valid on the cycle after rd_en; STATUS bit1=busy, bit0=done.

Function
REQ-019 SHALL implement the states IDLE, WR_TX, WR_CTRL, RD_STAT, WAIT_STAT, WR_CLR, RD_RX, WAIT_RX and RESP.
REQ-020 SHALL assert cmd_ready only in IDLE, and a command handshake (cmd_valid & cmd_ready) SHALL capture cmd_data and move to WR_TX.
REQ-021 SHALL, in WR_TX, drive wr_en=1, wr_addr=1 and wr_data=captured byte for one cycle, then go to WR_CTRL.
REQ-022 SHALL, in WR_CTRL, drive wr_en=1, wr_addr=0 and wr_data=CTRL_VAL for one cycle, then go to RD_STAT.
REQ-023 SHALL, in RD_STAT, drive rd_en=1 and rd_addr=2 for one cycle, then go to WAIT_STAT.
REQ-024 SHALL, in WAIT_STAT, sample rd_data, treat busy=0 & done=1 as complete, and increment the poll counter.
REQ-025 SHALL, from WAIT_STAT, go to WR_CLR if complete; else go to WR_CLR with the error flag set if the counter equals POLL_MAX; else return to RD_STAT.
REQ-026 SHALL, in WR_CLR, drive wr_en=1, wr_addr=0 and wr_data=0 for one cycle, then go to RD_RX if no error, else to RESP.
REQ-027 SHALL, in RD_RX, drive rd_en=1 and rd_addr=3, then in WAIT_RX capture rd_data into rsp_data and go to RESP.
REQ-028 SHALL, in RESP, hold rsp_valid=1 with stable rsp_data/rsp_err until rsp_ready=1, then return to IDLE.
REQ-029 SHALL, on error, set rsp_err=1 and rsp_data=0.
REQ-030 SHALL never assert wr_en and rd_en in the same cycle.
REQ-031 SHALL drive wr_en and rd_en to 0 in every state other than the strobe states named above.
REQ-032 SHALL produce the first rsp_valid exactly 8 cycles after the accepting handshake when done is seen on the first poll; each additional poll SHALL add 2 cycles.
REQ-033 SHALL clear the poll counter on every command acceptance, with the counter WIDTH-independent and 8 bits wide.
REQ-034 SHALL ignore cmd_valid outside IDLE (no queuing).

Reset
REQ-035 SHALL, while rst=1 at a clock edge, enter IDLE with wr_en, rd_en, wr_addr, rd_addr, wr_data, rsp_valid, rsp_data, rsp_err and the poll counter all 0; cmd_ready=1 after reset.
REQ-036 SHALL abandon an in-flight transfer on reset mid-operation with no response and no further bus strobes.

Verification
REQ-037 Single transfer: cmd 8'hA5, slave sets done on the 1st poll, rd_data(DATA_RX)=8'h3C -> writes (1,A5), (0,01), then one STATUS read, write (0,00), DATA_RX read; rsp_valid on cycle 8 with rsp_data=3C and rsp_err=0.
REQ-038 Slow slave: busy=1 for 3 polls, then done -> 4 STATUS reads, rsp_valid on cycle 14.
REQ-039 Timeout with POLL_MAX=4 and done never set -> 4 STATUS reads, CONTROL cleared, no DATA_RX read, rsp_err=1 and rsp_data=0.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout, return to IDLE one cycle after rsp_ready=1.
REQ-041 Reset asserted during RD_STAT -> next cycle all strobes are 0, state is IDLE and cmd_ready=1; a following cmd completes normally.
REQ-042 Throughout every test, an assertion SHALL check that wr_en&rd_en is never 1 and that cmd_ready=1 only when idle.
